// File: rtl/microwave.sv
// Microwave oven controller: keypad time entry, countdown and magnetron control.
// Ports:
//   clk          system clock, all state on rising edge
//   rst          synchronous active-high reset
//   kbd[9:0]     keypad level inputs, bit n = digit n
//   startn       start button, active-low level
//   stopn        stop/pause button, active-low level
//   clearn       clear button, active-low level
//   door_closed  1 = door closed
//   sec_ones_seg seconds-ones digit, 7-segment {g,f,e,d,c,b,a}
//   sec_tens_seg seconds-tens digit, same encoding
//   min_segs     minutes digit, same encoding
//   mag_on       magnetron enable, registered
// Build option: define MICROWAVE_SEG_ACTIVE_LOW_EN to invert all
// segment outputs for common-anode displays.
module microwave #(
    parameter int CLK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] kbd,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [6:0] sec_ones_seg,
    output logic [6:0] sec_tens_seg,
    output logic [6:0] min_segs,
    output logic       mag_on
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state;

    // Time digits M:T:O
    logic [3:0] min_d;
    logic [3:0] tens_d;
    logic [3:0] ones_d;

    logic [PW-1:0] presc;
    logic [9:0]    kbd_q;

    logic [9:0] new_keys;
    logic       key_hit;
    logic [3:0] key_val;

    logic       time_zero;
    logic       last_sec;
    logic       tick;
    logic       halt_req;

    logic [3:0] dec_m;
    logic [3:0] dec_t;
    logic [3:0] dec_o;

    assign new_keys  = kbd & ~kbd_q;
    assign time_zero = (min_d == 4'd0) && (tens_d == 4'd0)
                       && (ones_d == 4'd0);
    assign last_sec  = (min_d == 4'd0) && (tens_d == 4'd0)
                       && (ones_d == 4'd1);
    assign tick      = (presc == PRESC_MAX);
    // Stop or open door both suspend cooking and block lower-priority inputs
    assign halt_req  = !stopn || !door_closed;

    // Several new keys in one cycle: lowest index wins, so scan downward
    always_comb begin
        key_hit = 1'b0;
        key_val = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (new_keys[i]) begin
                key_hit = 1'b1;
                key_val = 4'(i);
            end
        end
    end

    // One-second decrement; tens may hold 6-9 and simply counts down from there
    always_comb begin
        dec_m = min_d;
        dec_t = tens_d;
        dec_o = ones_d;
        if (ones_d != 4'd0) begin
            dec_o = ones_d - 4'd1;
        end else if (tens_d != 4'd0) begin
            dec_t = tens_d - 4'd1;
            dec_o = 4'd9;
        end else if (min_d != 4'd0) begin
            dec_m = min_d - 4'd1;
            dec_t = 4'd5;
            dec_o = 4'd9;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            min_d  <= 4'd0;
            tens_d <= 4'd0;
            ones_d <= 4'd0;
            presc  <= '0;
            kbd_q  <= '0;
            mag_on <= 1'b0;
        end else begin
            kbd_q <= kbd;
            if (!clearn) begin
                state  <= IDLE;
                min_d  <= 4'd0;
                tens_d <= 4'd0;
                ones_d <= 4'd0;
                presc  <= '0;
                mag_on <= 1'b0;
            end else if (state == COOK) begin
                if (halt_req) begin
                    state  <= PAUSE;
                    mag_on <= 1'b0;
                end else if (tick) begin
                    presc  <= '0;
                    min_d  <= dec_m;
                    tens_d <= dec_t;
                    ones_d <= dec_o;
                    if (last_sec) begin
                        state  <= IDLE;
                        mag_on <= 1'b0;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end else begin
                if (halt_req) begin
                    state <= state;
                end else if (!startn) begin
                    if (!time_zero) begin
                        state  <= COOK;
                        presc  <= '0;
                        mag_on <= 1'b1;
                    end
                end else if (key_hit) begin
                    min_d  <= tens_d;
                    tens_d <= ones_d;
                    ones_d <= key_val;
                end
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
`ifdef MICROWAVE_SEG_ACTIVE_LOW_EN
        return ~s;
`else
        return s;
`endif
    endfunction

    assign sec_ones_seg = seg7(ones_d);
    assign sec_tens_seg = seg7(tens_d);
    assign min_segs     = seg7(min_d);

endmodule

// File: tb/tb_microwave.sv
// Self-checking bench for microwave: directed scenarios plus randomized
// cook sessions compared against a digit-level behavioural model.
module tb_microwave;

    localparam int HZ = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] kbd;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic [6:0] sec_ones_seg;
    logic [6:0] sec_tens_seg;
    logic [6:0] min_segs;
    logic       mag_on;

    int checks = 0;
    int errors = 0;

    // Model: displayed digits and whether the oven is cooking
    int em, et, eo;
    bit ecook;

    microwave #(.CLK_HZ(HZ)) dut (
        .clk(clk),
        .rst(rst),
        .kbd(kbd),
        .startn(startn),
        .stopn(stopn),
        .clearn(clearn),
        .door_closed(door_closed),
        .sec_ones_seg(sec_ones_seg),
        .sec_tens_seg(sec_tens_seg),
        .min_segs(min_segs),
        .mag_on(mag_on)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'h3F;
            1: s = 7'h06;
            2: s = 7'h5B;
            3: s = 7'h4F;
            4: s = 7'h66;
            5: s = 7'h6D;
            6: s = 7'h7D;
            7: s = 7'h07;
            8: s = 7'h7F;
            9: s = 7'h6F;
            default: s = 7'h00;
        endcase
`ifdef MICROWAVE_SEG_ACTIVE_LOW_EN
        s = ~s;
`endif
        return s;
    endfunction

    function automatic logic [20:0] dsp(input int m, input int t, input int o);
        return {seg(m), seg(t), seg(o)};
    endfunction

    function automatic logic [20:0] model_dsp();
        return dsp(em, et, eo);
    endfunction

    function automatic logic [20:0] got();
        return {min_segs, sec_tens_seg, sec_ones_seg};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        em = 0; et = 0; eo = 0;
        ecook = 0;
    endtask

    task automatic press(input int k);
        kbd = 10'd1 << k;
        step();
        kbd = '0;
        step();
        if (!ecook && door_closed) begin
            em = et; et = eo; eo = k;
        end
    endtask

    task automatic start_btn();
        startn = 1'b0;
        step();
        startn = 1'b1;
        if (!ecook && door_closed && (em + et + eo) != 0)
            ecook = 1;
    endtask

    task automatic stop_btn();
        stopn = 1'b0;
        step();
        stopn = 1'b1;
        ecook = 0;
    endtask

    task automatic clear_btn();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        model_clear();
    endtask

    // One countdown second as the spec defines it
    task automatic seconds(input int n);
        repeat (n) begin
            step(HZ);
            if (ecook) begin
                if (eo > 0) eo--;
                else if (et > 0) begin et--; eo = 9; end
                else if (em > 0) begin em--; et = 5; eo = 9; end
                if (em == 0 && et == 0 && eo == 0) ecook = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (got() !== dsp(0, 0, 0)) begin
            errors++;
            $display("FAIL reset_disp: got %h want %h", got(), dsp(0, 0, 0));
        end
        checks++;
        if (mag_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_mag: got %b want 0", mag_on);
        end
    endtask

    task automatic test_basic_cook();
        do_reset();
        press(1);
        press(2);
        start_btn();
        checks++;
        if (got() !== dsp(0, 1, 2) || mag_on !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: got %h/%b want %h/1",
                     got(), mag_on, dsp(0, 1, 2));
        end
        seconds(11);
        step(HZ - 1);
        checks++;
        if (got() !== dsp(0, 0, 1) || mag_on !== 1'b1) begin
            errors++;
            $display("FAIL basic_last: got %h/%b want %h/1",
                     got(), mag_on, dsp(0, 0, 1));
        end
        step(1);
        model_clear();
        checks++;
        if (got() !== dsp(0, 0, 0) || mag_on !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got %h/%b want %h/0",
                     got(), mag_on, dsp(0, 0, 0));
        end
        // Still idle: no further decrement or restart
        step(3 * HZ);
        checks++;
        if (got() !== dsp(0, 0, 0) || mag_on !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got %h/%b want %h/0",
                     got(), mag_on, dsp(0, 0, 0));
        end
    endtask

    task automatic test_stop_clear();
        do_reset();
        press(3);
        press(5);
        start_btn();
        seconds(5);
        stop_btn();
        step(2 * HZ);
        checks++;
        if (got() !== dsp(0, 3, 0) || mag_on !== 1'b0) begin
            errors++;
            $display("FAIL stop_hold: got %h/%b want %h/0",
                     got(), mag_on, dsp(0, 3, 0));
        end
        clear_btn();
        checks++;
        if (got() !== dsp(0, 0, 0) || mag_on !== 1'b0) begin
            errors++;
            $display("FAIL stop_clear: got %h/%b want %h/0",
                     got(), mag_on, dsp(0, 0, 0));
        end
    endtask

    task automatic test_minute_borrow();
        do_reset();
        press(1);
        press(2);
        press(9);
        checks++;
        if (got() !== dsp(1, 2, 9)) begin
            errors++;
            $display("FAIL borrow_entry: got %h want %h", got(), dsp(1, 2, 9));
        end
        start_btn();
        seconds(29);
        checks++;
        if (got() !== dsp(1, 0, 0) || mag_on !== 1'b1) begin
            errors++;
            $display("FAIL borrow_100: got %h/%b want %h/1",
                     got(), mag_on, dsp(1, 0, 0));
        end
        seconds(1);
        checks++;
        if (got() !== dsp(0, 5, 9) || mag_on !== 1'b1) begin
            errors++;
            $display("FAIL borrow_059: got %h/%b want %h/1",
                     got(), mag_on, dsp(0, 5, 9));
        end
    endtask

    task automatic test_door();
        do_reset();
        press(1);
        press(2);
        press(9);
        start_btn();
        seconds(3);
        door_closed = 1'b0;
        step();
        ecook = 0;
        step(HZ);
        checks++;
        if (got() !== dsp(1, 2, 6) || mag_on !== 1'b0) begin
            errors++;
            $display("FAIL door_open: got %h/%b want %h/0",
                     got(), mag_on, dsp(1, 2, 6));
        end
        door_closed = 1'b1;
        step(2 * HZ);
        checks++;
        if (got() !== dsp(1, 2, 6) || mag_on !== 1'b0) begin
            errors++;
            $display("FAIL door_closed_paused: got %h/%b want %h/0",
                     got(), mag_on, dsp(1, 2, 6));
        end
        start_btn();
        checks++;
        if (mag_on !== 1'b1) begin
            errors++;
            $display("FAIL door_resume: got %b want 1", mag_on);
        end
        seconds(1);
        checks++;
        if (got() !== dsp(1, 2, 5)) begin
            errors++;
            $display("FAIL door_resume_count: got %h want %h",
                     got(), dsp(1, 2, 5));
        end
    endtask

    task automatic test_ignored();
        do_reset();
        press(4);
        start_btn();
        press(7);
        checks++;
        if (got() !== dsp(0, 0, 4) || mag_on !== 1'b1) begin
            errors++;
            $display("FAIL key_in_cook: got %h/%b want %h/1",
                     got(), mag_on, dsp(0, 0, 4));
        end
        stop_btn();
        door_closed = 1'b0;
        step();
        start_btn();
        step();
        checks++;
        if (mag_on !== 1'b0) begin
            errors++;
            $display("FAIL start_door_open: got %b want 0", mag_on);
        end
        door_closed = 1'b1;
        clear_btn();
        start_btn();
        step();
        checks++;
        if (mag_on !== 1'b0 || got() !== dsp(0, 0, 0)) begin
            errors++;
            $display("FAIL start_zero: got %h/%b want %h/0",
                     got(), mag_on, dsp(0, 0, 0));
        end
    endtask

    task automatic test_clear_start();
        do_reset();
        press(8);
        clearn = 1'b0;
        startn = 1'b0;
        step();
        clearn = 1'b1;
        startn = 1'b1;
        model_clear();
        step();
        checks++;
        if (got() !== dsp(0, 0, 0) || mag_on !== 1'b0) begin
            errors++;
            $display("FAIL clear_start: got %h/%b want %h/0",
                     got(), mag_on, dsp(0, 0, 0));
        end
    endtask

    task automatic test_multi_key();
        do_reset();
        kbd = 10'b10_0010_1000;
        step();
        kbd = '0;
        step();
        checks++;
        if (got() !== dsp(0, 0, 3)) begin
            errors++;
            $display("FAIL multi_key: got %h want %h", got(), dsp(0, 0, 3));
        end
    endtask

    task automatic test_reset_midcook();
        do_reset();
        press(5);
        start_btn();
        seconds(2);
        rst = 1'b1;
        startn = 1'b0;
        step();
        rst = 1'b0;
        startn = 1'b1;
        model_clear();
        checks++;
        if (got() !== dsp(0, 0, 0) || mag_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_midcook: got %h/%b want %h/0",
                     got(), mag_on, dsp(0, 0, 0));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 12; it++) begin
            int nk;
            int ns;
            clear_btn();
            door_closed = ($urandom_range(0, 9) != 0);
            nk = $urandom_range(1, 3);
            for (int k = 0; k < nk; k++)
                press($urandom_range(0, 9));
            checks++;
            if (got() !== model_dsp()) begin
                errors++;
                $display("FAIL rand_entry[%0d]: got %h want %h",
                         it, got(), model_dsp());
            end
            start_btn();
            checks++;
            if (mag_on !== ecook) begin
                errors++;
                $display("FAIL rand_start[%0d]: got %b want %b",
                         it, mag_on, ecook);
            end
            door_closed = 1'b1;
            ns = $urandom_range(1, 8);
            for (int s = 0; s < ns; s++) begin
                seconds(1);
                checks++;
                if (got() !== model_dsp() || mag_on !== ecook) begin
                    errors++;
                    $display("FAIL rand_sec[%0d.%0d]: got %h/%b want %h/%b",
                             it, s, got(), mag_on, model_dsp(), ecook);
                end
            end
            stop_btn();
            checks++;
            if (got() !== model_dsp() || mag_on !== 1'b0) begin
                errors++;
                $display("FAIL rand_stop[%0d]: got %h/%b want %h/0",
                         it, got(), mag_on, model_dsp());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        kbd = '0;
        startn = 1'b1;
        stopn = 1'b1;
        clearn = 1'b1;
        door_closed = 1'b1;
        test_reset();
        test_basic_cook();
        test_stop_clear();
        test_minute_borrow();
        test_door();
        test_ignored();
        test_clear_start();
        test_multi_key();
        test_reset_midcook();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microwave.md
MICROWAVE -- requirements
Module: microwave

Interface
REQ-001 Parameter CLK_HZ, default 100, clock cycles per countdown second.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 kbd  input  10  keypad, bit n high = digit n pressed (level).
REQ-005 startn  input  1  start button, active-low level.
REQ-006 stopn  input  1  stop/pause button, active-low level.
REQ-007 clearn  input  1  clear button, active-low level.
REQ-008 door_closed  input  1  1 = door closed, 0 = open.
REQ-009 sec_ones_seg  output  7  seconds-ones digit, 7-segment, bit order {g,f,e,d,c,b,a}.
REQ-010 sec_tens_seg  output  7  seconds-tens digit, same encoding.
REQ-011 min_segs  output  7  minutes digit (0-9), same encoding.
REQ-012 mag_on  output  1  magnetron enable, registered.

Function
REQ-013 Time held as three BCD digits M:T:O (minutes, sec tens, sec ones), each 0-9.
REQ-014 States: IDLE, COOK, PAUSE; mag_on = 1 only in COOK.
REQ-015 Key press = rising edge of kbd (kbd registered each cycle; new bit set that was clear); multiple new bits: lowest index wins.
REQ-016 Key press in IDLE or PAUSE shifts digits left: M<=T, T<=O, O<=key; old M discarded (keys 1,2,9 give 1:29); ignored in COOK.
REQ-017 Per-cycle priority: clearn low > stopn low > door_closed low > startn low > key press.
REQ-018 clearn low: time <= 0:00, state <= IDLE, prescaler <= 0, any state.
REQ-019 stopn low in COOK: state <= PAUSE, time held; elsewhere no effect.
REQ-020 door_closed low in COOK: state <= PAUSE, time held; no automatic resume on close.
REQ-021 startn low with door_closed = 1 and time != 0:00, in IDLE or PAUSE: state <= COOK, prescaler <= 0; mag_on high on the following cycle.
REQ-022 startn low with door open or time 0:00: ignored.
REQ-023 startn held low while in COOK: no effect (level, not retriggering).
REQ-024 In COOK prescaler counts 0..CLK_HZ-1; at CLK_HZ-1 it wraps to 0 and time decrements by one second.
REQ-025 Decrement: O>0: O-1; else T>0: T-1, O=9; else M>0: M-1, T=5, O=9 (1:00 -> 0:59).
REQ-026 Digit values above 5 in T accepted and counted as entered (0:99 lasts 99 s).
REQ-027 Decrement reaching 0:00: state <= IDLE, mag_on low on the next cycle.
REQ-028 Prescaler held in IDLE/PAUSE.
REQ-029 Segments are combinational from the digit registers: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, active-high).

Reset
REQ-030 rst high: state IDLE, time 0:00, prescaler 0, kbd edge register 0, mag_on 0.
REQ-031 After reset all segment outputs show 0 (3F each); rst overrides every input, including mid-cook.

Configuration
REQ-032 MICROWAVE_SEG_ACTIVE_LOW_EN defined: all three segment outputs bitwise inverted (common-anode, 0 = 40 hex).
REQ-033 Not defined: active-high encoding per REQ-029.

Verification
REQ-034 rst, keys 1,2, startn low 1 cycle -> 0:12 shown, mag_on 1; after 12*CLK_HZ cycles 0:00, mag_on 0, state IDLE.
REQ-035 Keys 3,5, start, 5 s, stopn low -> mag_on 0, display 0:30 held; clearn low -> 0:00.
REQ-036 Keys 1,2,9, start -> 1:29; after 29 s shows 1:00, 1 s later 0:59.
REQ-037 Cooking 1:29, door_closed 0 after 3 s -> mag_on 0, 1:26 held; close door -> still paused; startn -> resumes.
REQ-038 Key 7 during COOK -> ignored; startn with door open or 0:00 -> mag_on stays 0.
REQ-039 clearn and startn low same cycle -> IDLE, 0:00, mag_on 0.
